// File: rtl/rgb_frame_reader.sv
// Streams a packed 24-bit RGB frame out of SRAM (3 words per 2 pixels) into a
// small pixel FIFO with start-of-line / end-of-frame flags per pixel.
module rgb_frame_reader #(
  parameter logic [17:0] BASE_ADDR  = 18'd146944,
  parameter int          WIDTH      = 320,
  parameter int          HEIGHT     = 240,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLOCK_50_I,
  input  logic        Reset,
  input  logic        start,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data,
  input  logic [15:0] SRAM_read_data,
  output logic [7:0]  pix_R,
  output logic [7:0]  pix_G,
  output logic [7:0]  pix_B,
  output logic        pix_sol,
  output logic        pix_eof,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int          WORDS     = WIDTH * HEIGHT * 3 / 2;
  localparam logic [17:0] LAST_ADDR = BASE_ADDR + 18'(WORDS - 1);
  localparam int          CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int          RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          NW        = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sol;
    logic       eof;
  } pix_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state, state_n;
  logic [1:0]      vld_pipe;      // tags for reads issued 1 and 2 cycles ago
  logic            issue, fetch_init, push, pop;
  logic [NW:0]     used;
  pix_t            fifo_mem [FIFO_DEPTH];
  pix_t            push_pix, head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   fifo_count;
  logic [1:0]      phase;
  logic [15:0]     hold;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign SRAM_we_n       = 1'b1;
  assign SRAM_write_data = 16'd0;

  // Every in-flight read reserves a FIFO slot, so a push can never overflow.
  assign used = (NW+1)'(fifo_count) + (NW+1)'(vld_pipe[0]) + (NW+1)'(vld_pipe[1]);

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    fetch_init = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n    = FETCH;
        fetch_init = 1'b1;
      end
      FETCH: if (used < (NW+1)'(FIFO_DEPTH)) begin
        issue = 1'b1;
        if (SRAM_address == LAST_ADDR) state_n = DRAIN;
      end
      DRAIN: if (vld_pipe == 2'b00 && fifo_count == '0) begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Triplet unpack: w0={R0,G0} held, w1={B0,R1} completes pixel 0, w2={G1,B1}.
  always_comb begin
    push     = 1'b0;
    push_pix = '0;
    if (vld_pipe[1]) begin
      case (phase)
        2'd1: begin
          push     = 1'b1;
          push_pix = {hold[15:8], hold[7:0], SRAM_read_data[15:8], col == '0,
                      (col == CW'(WIDTH - 1)) && (row == RW'(HEIGHT - 1))};
        end
        2'd2: begin
          push     = 1'b1;
          push_pix = {hold[15:8], SRAM_read_data[15:8], SRAM_read_data[7:0], col == '0,
                      (col == CW'(WIDTH - 1)) && (row == RW'(HEIGHT - 1))};
        end
        default: ;
      endcase
    end
  end

  assign pix_valid = (fifo_count != '0);
  assign pop       = pix_valid & pix_ready;
  assign head      = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign {pix_R, pix_G, pix_B, pix_sol, pix_eof} = head;

  always_ff @(posedge CLOCK_50_I) begin
    if (push) fifo_mem[wr_ptr] <= push_pix;
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      SRAM_address <= BASE_ADDR;
      vld_pipe     <= '0;
      phase        <= '0;
      hold         <= '0;
      col          <= '0;
      row          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], issue};
      if (issue && SRAM_address != LAST_ADDR) SRAM_address <= SRAM_address + 18'd1;
      if (vld_pipe[1]) begin
        phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
        if (phase == 2'd0) hold       <= SRAM_read_data;
        if (phase == 2'd1) hold[15:8] <= SRAM_read_data[7:0];
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (col == CW'(WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (fetch_init) begin
        SRAM_address <= BASE_ADDR;
        phase        <= '0;
        col          <= '0;
        row          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Directed bench for rgb_frame_reader: reduced-height frame ending at the top of
// SRAM, 2-cycle SRAM model, and a transfer monitor compared against a pixel model.
module tb_rgb_frame_reader;

  localparam int          W      = 320;
  localparam int          H      = 4;
  localparam int          NPIX   = W * H;
  localparam int          NWORDS = NPIX * 3 / 2;
  localparam logic [17:0] BASE   = 18'(262144 - NWORDS);
  localparam logic [17:0] LAST   = 18'd262143;

  logic        clk = 1'b0;
  logic        Reset, start, done, we_n, pix_valid, pix_ready, pix_sol, pix_eof;
  logic [17:0] addr;
  logic [15:0] wdata, rdata, d1, d2;
  logic [7:0]  R, G, B;
  logic        mon_clr;
  int          checks = 0, errors = 0, cyc = 0;
  int          xfer, pix_bad, sol_cnt, eof_cnt, done_cnt;

  always #10 clk = ~clk;

  rgb_frame_reader #(.BASE_ADDR(BASE), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4)) dut (
    .CLOCK_50_I(clk), .Reset(Reset), .start(start), .done(done),
    .SRAM_address(addr), .SRAM_we_n(we_n), .SRAM_write_data(wdata),
    .SRAM_read_data(rdata), .pix_R(R), .pix_G(G), .pix_B(B),
    .pix_sol(pix_sol), .pix_eof(pix_eof), .pix_valid(pix_valid), .pix_ready(pix_ready));

  function automatic logic [15:0] sram_fn(input logic [17:0] a);
    if (a == BASE)          return 16'h1122;
    if (a == BASE + 18'd1)  return 16'h3344;
    if (a == BASE + 18'd2)  return 16'h5566;
    return (a[15:0] * 16'd40503) ^ {14'd0, a[17:16]} ^ 16'h3C5A;
  endfunction

  // Expected {R,G,B,sol,eof} of frame pixel k.
  function automatic logic [25:0] exp_pix(input int k);
    int w;
    logic [15:0] a, b, c;
    logic sol, eof;
    w   = 3 * (k / 2);
    a   = sram_fn(BASE + 18'(w));
    b   = sram_fn(BASE + 18'(w + 1));
    c   = sram_fn(BASE + 18'(w + 2));
    sol = (k % W) == 0;
    eof = (k == NPIX - 1);
    if (k % 2 == 0) return {a[15:8], a[7:0], b[15:8], sol, eof};
    return {b[7:0], c[15:8], c[7:0], sol, eof};
  endfunction

  always @(posedge clk) begin
    d1 <= sram_fn(addr);
    d2 <= d1;
  end
  assign rdata = d2;

  always @(negedge clk) begin
    if (mon_clr) begin
      xfer = 0; pix_bad = 0; sol_cnt = 0; eof_cnt = 0; done_cnt = 0;
    end else begin
      if (done) done_cnt++;
      if (pix_valid && pix_ready) begin
        if ({R, G, B, pix_sol, pix_eof} !== exp_pix(xfer)) pix_bad++;
        if (pix_sol) sol_cnt++;
        if (pix_eof) eof_cnt++;
        xfer++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  // Pulses start in cycle 0 and checks the address/pixel latency through cycle 6.
  task automatic start_frame(input string tag);
    clr_mon();
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    chk({tag, "_addr_c1"}, 32'(addr), 32'(BASE));
    tick();
    chk({tag, "_addr_c2"}, 32'(addr), 32'(BASE + 18'd1));
    tick();
    tick();
    chk({tag, "_valid_c4"}, 32'(pix_valid), 32'd0);
    tick();
    chk({tag, "_valid_c5"}, 32'(pix_valid), 32'd1);
    chk({tag, "_pix0"}, 32'({R, G, B, pix_sol, pix_eof}), 32'({24'h112233, 1'b1, 1'b0}));
    tick();
    chk({tag, "_pix1"}, 32'({R, G, B, pix_sol, pix_eof}), 32'({24'h445566, 1'b0, 1'b0}));
  endtask

  task automatic wait_done(input string tag);
    while (!done && cyc < NWORDS + 400) tick();
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_last_addr"}, 32'(addr), 32'(LAST));
    tick();
    tick();
    chk({tag, "_xfers"}, 32'(xfer), 32'(NPIX));
    chk({tag, "_pix_bad"}, 32'(pix_bad), 32'd0);
    chk({tag, "_sol_cnt"}, 32'(sol_cnt), 32'(H));
    chk({tag, "_eof_cnt"}, 32'(eof_cnt), 32'd1);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_idle_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_idle_addr"}, 32'(addr), 32'(LAST));
  endtask

  task automatic wait_xfer(input int n);
    int t = 0;
    while (xfer < n && t < NWORDS + 400) begin
      tick();
      t++;
    end
    chk("xfer_reached", 32'(xfer >= n), 32'd1);
  endtask

  initial begin
    int head_bad, addr_bad, fifo_max, done_at;
    logic [25:0] held;
    logic [17:0] held_addr;
    Reset = 1'b1; start = 1'b0; pix_ready = 1'b1; mon_clr = 1'b1;
    repeat (2) tick();
    chk("rst_we_n",  32'(we_n), 32'd1);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_addr",  32'(addr), 32'(BASE));
    chk("rst_pix",   32'({R, G, B, pix_sol, pix_eof}), 32'd0);
    Reset = 1'b0;
    tick();

    // Undisturbed frame, completion time within 1920+5 +/-2 cycles.
    start_frame("f1");
    while (!done && cyc < NWORDS + 400) tick();
    done_at = cyc;
    chk("f1_done_window", 32'(done_at >= NWORDS + 3 && done_at <= NWORDS + 7), 32'd1);
    wait_done("f1");

    // 50-cycle back-pressure mid-row.
    start_frame("f2");
    wait_xfer(200);
    pix_ready = 1'b0;
    head_bad = 0; addr_bad = 0; fifo_max = 0;
    repeat (10) begin
      tick();
      if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
    end
    held      = {R, G, B, pix_sol, pix_eof};
    held_addr = addr;
    repeat (40) begin
      tick();
      if (int'(dut.fifo_count) > fifo_max) fifo_max = int'(dut.fifo_count);
      if (!pix_valid || {R, G, B, pix_sol, pix_eof} !== held) head_bad++;
      if (addr !== held_addr) addr_bad++;
    end
    chk("stall_head_stable", 32'(head_bad), 32'd0);
    chk("stall_addr_frozen", 32'(addr_bad), 32'd0);
    chk("stall_fifo_le4", 32'(fifo_max <= 4), 32'd1);
    chk("stall_no_xfer", 32'(xfer), 32'd200);
    pix_ready = 1'b1;
    wait_done("f2");

    // start re-pulsed during FETCH must be ignored.
    start_frame("f3");
    repeat (100) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("f3");

    // Mid-frame reset after transfer 1000, then a fresh frame.
    start_frame("f4a");
    wait_xfer(1000);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_valid", 32'(pix_valid), 32'd0);
    chk("mid_rst_addr",  32'(addr), 32'(BASE));
    chk("mid_rst_done",  32'(done), 32'd0);
    tick();
    start_frame("f4b");
    wait_done("f4b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
